shift_operand_stage: RTL
========================

SHIFT_OPERAND_STAGE -- requirements
Module: shift_operand_stage

Interface
REQ-001 Parameter TAG_W, default 4: width of the request tag carried alongside each shift operation.
REQ-002 Port clock, input, 1: single clock, rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port io_in_valid, input, 1: upstream request valid.
REQ-005 Port io_in_ready, output, 1: stage can accept a request this cycle.
REQ-006 Port io_in_bits_op, input, 4: operation code (0 SLL, 1 SRL, 2 SRA, 4 SLLW, 5 SRLW, 6 SRAW, others illegal).
REQ-007 Port io_in_bits_src, input, 64: operand to shift.
REQ-008 Port io_in_bits_amt, input, 64: shift-amount register value; only low bits are used.
REQ-009 Port io_in_bits_tag, input, TAG_W: opaque request tag.
REQ-010 Port io_out_valid, output, 1: head entry is presented to the barrel shifter.
REQ-011 Port io_out_ready, input, 1: downstream consumes the head entry.
REQ-012 Port io_out_data, output, 64: shifter data operand.
REQ-013 Port io_out_shiftAmount, output, 6: shifter amount.
REQ-014 Port io_out_dir, output, 6: shifter direction code (0x0B left logical, 0x0C right logical, 0x0D right arithmetic).
REQ-015 Port io_out_word, output, 1: entry is a 32-bit word operation.
REQ-016 Port io_out_tag, output, TAG_W: tag of the head entry.
REQ-017 Port io_illegalCount, output, 8: saturating count of illegal ops received.

Function
REQ-018 The stage SHALL be a 2-entry in-order FIFO of decoded requests; io_in_ready = (occupancy < 2), and io_in_ready SHALL NOT depend on io_out_ready.
REQ-019 A request SHALL be accepted iff io_in_valid && io_in_ready; a head entry SHALL be retired iff io_out_valid && io_out_ready.
REQ-020 Latency SHALL be exactly 1 cycle: a request accepted into an empty stage at edge N SHALL appear with io_out_valid=1 after edge N.
REQ-021 Simultaneous accept and retire SHALL leave occupancy unchanged and preserve order; at occupancy 2 no accept is possible, even if a retire occurs that cycle.
REQ-022 io_out_valid = (occupancy > 0); while io_out_valid=0, io_out_data, io_out_shiftAmount, io_out_dir, io_out_word and io_out_tag SHALL be 0.
REQ-023 Head outputs SHALL be driven from registers and SHALL remain stable while io_out_valid=1 and io_out_ready=0.
REQ-024 Decode: SLL -> dir 0x0B; SRL -> dir 0x0C; SRA -> dir 0x0D; data = src; shiftAmount = amt[5:0]; word = 0.
REQ-025 An illegal op SHALL be accepted (handshake completes) but SHALL NOT be enqueued, and io_illegalCount SHALL increment by 1, saturating at 255.
REQ-026 An occupancy counter SHALL track 0..2; wrap of the internal read/write pointers SHALL be modulo 2.

Reset
REQ-027 Asserting reset SHALL immediately empty the FIFO, drive io_out_valid=0, io_in_ready=1 and all data outputs to 0, and clear io_illegalCount; entries in flight are discarded.
REQ-028 In the first clock edge after reset deasserts, a valid request SHALL be accepted normally.

Configuration
REQ-029 Macro SHIFT_STAGE_WORD32_EN: when defined, ops 4/5/6 SHALL be legal with shiftAmount = {1'b0, amt[4:0]}, word = 1, and data as follows: SLLW -> zero-extended src[31:0] with dir 0x0B; SRLW -> zero-extended src[31:0] with dir 0x0C; SRAW -> src[31:0] sign-extended from bit 31 with dir 0x0D.
REQ-030 When SHIFT_STAGE_WORD32_EN is undefined, ops 4/5/6 SHALL be treated as illegal per REQ-025, and io_out_word SHALL be constant 0.

Verification
REQ-031 Empty stage, push SRA, src=0x8000_0000_0000_0000, amt=0x43 -> next cycle: out_valid=1, dir=0x0D, shiftAmount=3, data unchanged.
REQ-032 Hold io_out_ready=0, push 3 back-to-back requests -> two are accepted, io_in_ready=0 from the second edge onward; the outputs stay on the first request until io_out_ready=1, then tags retire in order.
REQ-033 Occupancy 1, simultaneous push and pop for 10 cycles -> occupancy stays 1, no request is lost, and the tags come out in order.
REQ-034 Push op=0x9 three hundred times -> nothing is enqueued, io_illegalCount=255, out_valid stays 0.
REQ-035 With WORD32 enabled, SRAW src=0x0000_0000_FFFF_FFF0, amt=0x3F -> data=0xFFFF_FFFF_FFFF_FFF0, shiftAmount=31, word=1; with it disabled, the same push increments io_illegalCount instead.
REQ-036 Assert reset mid-cycle with occupancy 2 -> outputs go to 0 and io_in_ready=1 without waiting for a clock edge; after deassertion, the first request pushed appears after 1 cycle.

Source files
------------

// File: rtl/shift_operand_stage.sv
// Two-entry in-order operand FIFO that decodes shift requests for a barrel shifter.
// Define SHIFT_STAGE_WORD32_EN to make the 32-bit word ops (SLLW/SRLW/SRAW) legal.
module shift_operand_stage #(
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [3:0]       io_in_bits_op,
    input  logic [63:0]      io_in_bits_src,
    input  logic [63:0]      io_in_bits_amt,
    input  logic [TAG_W-1:0] io_in_bits_tag,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [63:0]      io_out_data,
    output logic [5:0]       io_out_shiftAmount,
    output logic [5:0]       io_out_dir,
    output logic             io_out_word,
    output logic [TAG_W-1:0] io_out_tag,
    output logic [7:0]       io_illegalCount
);

    localparam logic [5:0] DIR_SLL = 6'h0B;
    localparam logic [5:0] DIR_SRL = 6'h0C;
    localparam logic [5:0] DIR_SRA = 6'h0D;

    logic             dec_legal;
    logic [63:0]      dec_data;
    logic [5:0]       dec_amt;
    logic [5:0]       dec_dir;
    logic             dec_word;

    logic [63:0]      data_q  [2];
    logic [5:0]       amt_q   [2];
    logic [5:0]       dir_q   [2];
    logic             word_q  [2];
    logic [TAG_W-1:0] tag_q   [2];

    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q,  count_d;
    logic [7:0]       illegal_q, illegal_d;

    logic             in_fire;
    logic             enq;
    logic             deq;

    // Only amt[5:0] ever reaches the shifter.
    logic unused_amt;
    assign unused_amt = ^io_in_bits_amt[63:6];

    always_comb begin
        dec_legal = 1'b1;
        dec_data  = io_in_bits_src;
        dec_amt   = io_in_bits_amt[5:0];
        dec_dir   = DIR_SLL;
        dec_word  = 1'b0;
        case (io_in_bits_op)
            4'd0: dec_dir = DIR_SLL;
            4'd1: dec_dir = DIR_SRL;
            4'd2: dec_dir = DIR_SRA;
`ifdef SHIFT_STAGE_WORD32_EN
            4'd4: begin
                dec_dir  = DIR_SLL;
                dec_data = {32'b0, io_in_bits_src[31:0]};
                dec_amt  = {1'b0, io_in_bits_amt[4:0]};
                dec_word = 1'b1;
            end
            4'd5: begin
                dec_dir  = DIR_SRL;
                dec_data = {32'b0, io_in_bits_src[31:0]};
                dec_amt  = {1'b0, io_in_bits_amt[4:0]};
                dec_word = 1'b1;
            end
            4'd6: begin
                dec_dir  = DIR_SRA;
                dec_data = {{32{io_in_bits_src[31]}}, io_in_bits_src[31:0]};
                dec_amt  = {1'b0, io_in_bits_amt[4:0]};
                dec_word = 1'b1;
            end
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    assign io_in_ready  = (count_q != 2'd2);
    assign io_out_valid = (count_q != 2'd0);
    assign in_fire      = io_in_valid && io_in_ready;
    assign enq          = in_fire && dec_legal;
    assign deq          = io_out_valid && io_out_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q ^ enq;
        rd_ptr_d  = rd_ptr_q ^ deq;
        count_d   = count_q + {1'b0, enq} - {1'b0, deq};
        illegal_d = illegal_q;
        if (in_fire && !dec_legal && illegal_q != 8'hFF) begin
            illegal_d = illegal_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            illegal_q <= 8'd0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                amt_q[i]  <= '0;
                dir_q[i]  <= '0;
                word_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            if (enq) begin
                data_q[wr_ptr_q] <= dec_data;
                amt_q[wr_ptr_q]  <= dec_amt;
                dir_q[wr_ptr_q]  <= dec_dir;
                word_q[wr_ptr_q] <= dec_word;
                tag_q[wr_ptr_q]  <= io_in_bits_tag;
            end
        end
    end

    // Head fields are forced to zero whenever the FIFO is empty.
    assign io_out_data        = io_out_valid ? data_q[rd_ptr_q] : 64'd0;
    assign io_out_shiftAmount = io_out_valid ? amt_q[rd_ptr_q]  : 6'd0;
    assign io_out_dir         = io_out_valid ? dir_q[rd_ptr_q]  : 6'd0;
    assign io_out_tag         = io_out_valid ? tag_q[rd_ptr_q]  : '0;
`ifdef SHIFT_STAGE_WORD32_EN
    assign io_out_word        = io_out_valid ? word_q[rd_ptr_q] : 1'b0;
`else
    logic unused_word;
    assign unused_word = word_q[0] ^ word_q[1];
    assign io_out_word = 1'b0;
`endif
    assign io_illegalCount    = illegal_q;

endmodule
